mem_depart: RTL and testbench
=============================

// Module: mem_depart
// PURPOSE
//  MEM stage directly downstream of the EX stage. Takes EX results (aluop, effective address,
//  store data, dest reg/write-enable/value) and either passes ALU results through to WB or
//  runs a load/store on a req/ack data-memory port. Stalls upstream while an access is pending.
//  Byte/half/word loads are extended here; stores drive byte enables.
// PARAMETERS
//  ACK_TIMEOUT  0   cycles to wait for dmem_ack_i before aborting; 0 = wait forever
// PORTS
//  clk              in   1   stage clock
//  reset_n          in   1   synchronous, active-low reset
//  ex_valid_i       in   1   EX outputs valid this cycle
//  ex_aluop_i       in   8   EX aluop
//  ex_mem_addr_i    in   32  load/store effective address
//  ex_store_data_i  in   32  store data (rt)
//  ex_wd_i          in   5   destination register
//  ex_wreg_i        in   1   destination write enable (already overflow-qualified by EX)
//  ex_wdata_i       in   32  ALU result for non-memory ops
//  stall_req_o      out  1   1 = upstream must hold EX outputs
//  dmem_req_o       out  1   memory request, held until ack
//  dmem_we_o        out  1   1 = store
//  dmem_addr_o      out  32  word address ({addr[31:2],2'b00})
//  dmem_be_o        out  4   byte enables (bit0 = addr byte 0, little-endian)
//  dmem_wdata_o     out  32  lane-replicated store data
//  dmem_ack_i       in   1   access complete; rdata valid same cycle
//  dmem_rdata_i     in   32  read word
//  wb_valid_o       out  1   WB outputs valid (one-cycle pulse per instruction)
//  wb_wd_o          out  5   WB dest register
//  wb_wreg_o        out  1   WB write enable
//  wb_wdata_o       out  32  WB write value
//  bus_err_o        out  1   one-cycle pulse: access aborted by timeout
//  align_exc_o      out  2   {ades,adel} one-cycle pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE, all outputs 0, timeout counter 0. Reset mid-ACCESS
//   drops dmem_req_o next edge; the pending instruction produces no WB.
//  States: IDLE, ACCESS. stall_req_o = (state==ACCESS), combinational.
//  IDLE, ex_valid_i=0: wb_valid_o<=0, wb_wreg_o<=0.
//  IDLE, valid non-memory op: wb_* <= ex_* ; wb_valid_o<=1 (latency 1 cycle).
//  IDLE, valid load/store: latch op/addr/data, state<=ACCESS, wb_valid_o<=0,
//   dmem_* registered from latch; dmem_req_o=1 from next cycle.
//  ACCESS: dmem_* held stable; ex_* ignored. On edge with dmem_ack_i=1: state<=IDLE,
//   dmem_req_o<=0, wb_valid_o<=1, wb_wd_o<=latched wd; load: wb_wreg_o<=latched wreg,
//   wb_wdata_o<=formatted rdata; store: wb_wreg_o<=0.
//  Min memory-op latency: capture edge + ack edge; one bubble cycle follows (stall drops at IDLE).
//  Timeout (ACK_TIMEOUT>0): counter increments each ACCESS cycle without ack; on reaching
//   ACK_TIMEOUT: state<=IDLE, req<=0, bus_err_o pulses 1 cycle, wb_valid_o<=1, wb_wreg_o<=0.
//   Ack on the same edge as the limit wins (normal completion).
//  Loads (dmem_be_o=4'hF): LB/LBU pick byte addr[1:0], sign/zero extend; LH/LHU pick
//   half addr[1], sign/zero extend; LW whole word.
//  Stores: SB be=1<<addr[1:0], wdata={4{d[7:0]}}; SH be=addr[1]?4'hC:4'h3, wdata={2{d[15:0]}};
//   SW be=4'hF, wdata=d.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]!=0 or LW/SW with addr[1:0]!=0 issue no
//   access, stay IDLE, wb_valid_o<=1, wb_wreg_o<=0, wb_wdata_o<=bad address, align_exc_o
//   pulses 2'b01 (load) / 2'b10 (store).
//  Undefined: align_exc_o tied 0; misaligned low bits ignored (half uses addr[1], word aligned).
// STRUCTURE
//  Shared package pipe_defs_pkg: aluop constants LB=8'hE0 LBU=8'hE4 LH=8'hE1 LHU=8'hE5
//   LW=8'hE3 SB=8'hE8 SH=8'hE9 SW=8'hEB (disjoint from existing ALU codes); is_load/is_store
//   helpers; MEM FSM state encoding.
//  Sub-module mem_lane_fmt (combinational): store be/wdata generation and load extraction.
// TESTING
//  1 ADDU pass-through: aluop 8'h21, wd=5, wdata=32'h1234 -> next cycle wb_valid=1, wd=5, wdata=32'h1234, no req.
//  2 LB addr 32'h103, rdata 32'h80FF_0000, ack after 3 cycles -> stall high 3 cycles, wb_wdata=32'hFFFF_FF80.
//  3 SH addr 32'h102 data 32'h0000_BEEF -> dmem_we=1, be=4'hC, wdata=32'hBEEF_BEEF, wb_wreg=0.
//  4 LHU addr 32'h200, rdata 32'h0000_9ABC, ack immediately -> wb_wdata=32'h0000_9ABC, one bubble cycle.
//  5 ACK_TIMEOUT=4, never ack -> bus_err pulse after 4 ACCESS cycles, req drops, no reg write.
//  6 reset_n=0 during ACCESS -> next cycle req=0, stall=0, wb_valid=0; with MEM_ALIGN_CHECK_EN,
//    LW addr 32'h101 -> align_exc=2'b01, no req.

Source files
------------

// File: rtl/pipe_defs_pkg.sv
// Shared pipeline definitions: memory aluop codes, load/store classifiers and MEM FSM states.
package pipe_defs_pkg;

  localparam logic [7:0] OpLb  = 8'hE0;
  localparam logic [7:0] OpLbu = 8'hE4;
  localparam logic [7:0] OpLh  = 8'hE1;
  localparam logic [7:0] OpLhu = 8'hE5;
  localparam logic [7:0] OpLw  = 8'hE3;
  localparam logic [7:0] OpSb  = 8'hE8;
  localparam logic [7:0] OpSh  = 8'hE9;
  localparam logic [7:0] OpSw  = 8'hEB;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } mem_state_e;

  function automatic logic is_load(input logic [7:0] op);
    is_load = (op == OpLb) || (op == OpLbu) || (op == OpLh) || (op == OpLhu) || (op == OpLw);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    is_store = (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
    is_misaligned = 1'b0;
    if ((op == OpLh) || (op == OpLhu) || (op == OpSh)) begin
      is_misaligned = addr_lo[0];
    end else if ((op == OpLw) || (op == OpSw)) begin
      is_misaligned = (addr_lo != 2'b00);
    end
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting for the MEM stage: store byte enables / replicated write data, and
// load byte/half extraction with sign or zero extension.
module mem_lane_fmt
  import pipe_defs_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be       = 4'hF;
    wdata    = store_data;
    ldata    = rdata;
    case (aluop)
      OpSb: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      OpSh: begin
        be    = addr_lo[1] ? 4'hC : 4'h3;
        wdata = {2{store_data[15:0]}};
      end
      OpLb:    ldata = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   ldata = {24'h0, byte_sel};
      OpLh:    ldata = {{16{half_sel[15]}}, half_sel};
      OpLhu:   ldata = {16'h0, half_sel};
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mem_depart.sv
// MEM stage: ALU pass-through to WB, or a req/ack data-memory load/store with upstream stall.
// Optional alignment exceptions are built when MEM_ALIGN_CHECK_EN is defined.
module mem_depart
  import pipe_defs_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid_i,
  input  logic [7:0]  ex_aluop_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  output logic        stall_req_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic        bus_err_o,
  output logic [1:0]  align_exc_o
);

  mem_state_e  state_q, state_d;
  logic [7:0]  op_q;
  logic [31:0] addr_q;
  logic [4:0]  wd_q;
  logic        wreg_q;
  logic [31:0] tmo_q;

  logic        ex_mem, misalign, capture, ack_done, tmo_hit;
  logic [7:0]  fmt_op;
  logic [1:0]  fmt_addr_lo;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_ldata;

  // Idle: format the incoming store; Access: extract the returning load with latched op/addr.
  assign fmt_op      = (state_q == StIdle) ? ex_aluop_i : op_q;
  assign fmt_addr_lo = (state_q == StIdle) ? ex_mem_addr_i[1:0] : addr_q[1:0];

  mem_lane_fmt u_lane_fmt (
    .aluop      (fmt_op),
    .addr_lo    (fmt_addr_lo),
    .store_data (ex_store_data_i),
    .rdata      (dmem_rdata_i),
    .be         (fmt_be),
    .wdata      (fmt_wdata),
    .ldata      (fmt_ldata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (capture) state_d = StAccess;
      StAccess: if (ack_done || tmo_hit) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_req_o = (state_q == StAccess);
    ex_mem      = ex_valid_i && (is_load(ex_aluop_i) || is_store(ex_aluop_i));
`ifdef MEM_ALIGN_CHECK_EN
    misalign    = ex_mem && is_misaligned(ex_aluop_i, ex_mem_addr_i[1:0]);
`else
    misalign    = 1'b0;
`endif
    capture     = (state_q == StIdle) && ex_mem && !misalign;
    ack_done    = (state_q == StAccess) && dmem_ack_i;
    // An ack on the limit edge wins over the abort.
    tmo_hit     = (state_q == StAccess) && !dmem_ack_i && (ACK_TIMEOUT != 0) &&
                  (tmo_q == ACK_TIMEOUT - 1);
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic [1:0] align_exc_q;
  assign align_exc_o = align_exc_q;
`else
  assign align_exc_o = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q         <= '0;
      addr_q       <= '0;
      wd_q         <= '0;
      wreg_q       <= 1'b0;
      tmo_q        <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_wd_o      <= '0;
      wb_wreg_o    <= 1'b0;
      wb_wdata_o   <= '0;
      bus_err_o    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      align_exc_q  <= 2'b00;
`endif
    end else begin
      bus_err_o <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      align_exc_q <= 2'b00;
`endif
      if (state_q == StIdle) begin
        tmo_q <= '0;
        if (!ex_valid_i) begin
          wb_valid_o <= 1'b0;
          wb_wreg_o  <= 1'b0;
        end else if (misalign) begin
          wb_valid_o <= 1'b1;
          wb_wd_o    <= ex_wd_i;
          wb_wreg_o  <= 1'b0;
          wb_wdata_o <= ex_mem_addr_i;
`ifdef MEM_ALIGN_CHECK_EN
          align_exc_q <= is_load(ex_aluop_i) ? 2'b01 : 2'b10;
`endif
        end else if (capture) begin
          op_q         <= ex_aluop_i;
          addr_q       <= ex_mem_addr_i;
          wd_q         <= ex_wd_i;
          wreg_q       <= ex_wreg_i;
          wb_valid_o   <= 1'b0;
          wb_wreg_o    <= 1'b0;
          dmem_req_o   <= 1'b1;
          dmem_we_o    <= is_store(ex_aluop_i);
          dmem_addr_o  <= {ex_mem_addr_i[31:2], 2'b00};
          dmem_be_o    <= fmt_be;
          dmem_wdata_o <= fmt_wdata;
        end else begin
          wb_valid_o <= 1'b1;
          wb_wd_o    <= ex_wd_i;
          wb_wreg_o  <= ex_wreg_i;
          wb_wdata_o <= ex_wdata_i;
        end
      end else if (ack_done) begin
        tmo_q      <= '0;
        dmem_req_o <= 1'b0;
        wb_valid_o <= 1'b1;
        wb_wd_o    <= wd_q;
        wb_wreg_o  <= is_load(op_q) && wreg_q;
        if (is_load(op_q)) begin
          wb_wdata_o <= fmt_ldata;
        end
      end else if (tmo_hit) begin
        tmo_q      <= '0;
        dmem_req_o <= 1'b0;
        bus_err_o  <= 1'b1;
        wb_valid_o <= 1'b1;
        wb_wd_o    <= wd_q;
        wb_wreg_o  <= 1'b0;
      end else begin
        tmo_q      <= tmo_q + 32'd1;
        wb_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_depart.sv
// Self-checking bench for mem_depart with ACK_TIMEOUT=4: directed cases then random traffic
// against a behavioural memory-stage model.
module tb_mem_depart;

  localparam int unsigned Tmo = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid_i;
  logic [7:0]  ex_aluop_i;
  logic [31:0] ex_mem_addr_i, ex_store_data_i, ex_wdata_i;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic        stall_req_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o, wb_wreg_o, bus_err_o;
  logic [4:0]  wb_wd_o;
  logic [31:0] wb_wdata_o;
  logic [1:0]  align_exc_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_depart #(.ACK_TIMEOUT(Tmo)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ex_valid_i      (ex_valid_i),
    .ex_aluop_i      (ex_aluop_i),
    .ex_mem_addr_i   (ex_mem_addr_i),
    .ex_store_data_i (ex_store_data_i),
    .ex_wd_i         (ex_wd_i),
    .ex_wreg_i       (ex_wreg_i),
    .ex_wdata_i      (ex_wdata_i),
    .stall_req_o     (stall_req_o),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_be_o       (dmem_be_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_ack_i      (dmem_ack_i),
    .dmem_rdata_i    (dmem_rdata_i),
    .wb_valid_o      (wb_valid_o),
    .wb_wd_o         (wb_wd_o),
    .wb_wreg_o       (wb_wreg_o),
    .wb_wdata_o      (wb_wdata_o),
    .bus_err_o       (bus_err_o),
    .align_exc_o     (align_exc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic bit m_is_load(input logic [7:0] op);
    return op == 8'hE0 || op == 8'hE4 || op == 8'hE1 || op == 8'hE5 || op == 8'hE3;
  endfunction

  function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] addr);
    int lo = int'(addr % 4);
    if (op == 8'hE1 || op == 8'hE5 || op == 8'hE9) return (lo % 2) != 0;
    if (op == 8'hE3 || op == 8'hEB) return lo != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [7:0] op, input logic [31:0] addr);
    int lo = int'(addr % 4);
    if (op == 8'hE8) return 4'(1 << lo);
    if (op == 8'hE9) return (lo >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] d);
    if (op == 8'hE8) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (op == 8'hE9) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> (8 * int'(addr % 4)));
    h = 16'(rd >> (((addr % 4) >= 2) ? 16 : 0));
    case (op)
      8'hE0:   return 32'(signed'(b));
      8'hE4:   return 32'(b);
      8'hE1:   return 32'(signed'(h));
      8'hE5:   return 32'(h);
      default: return rd;
    endcase
  endfunction

  task automatic do_alu(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata);
    ex_valid_i = 1'b1; ex_aluop_i = op; ex_wd_i = wd; ex_wreg_i = wreg; ex_wdata_i = wdata;
    ex_mem_addr_i = $urandom; ex_store_data_i = $urandom;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    chk("alu_valid", 32'(wb_valid_o), 32'd1);
    chk("alu_wd", 32'(wb_wd_o), 32'(wd));
    chk("alu_wreg", 32'(wb_wreg_o), 32'(wreg));
    chk("alu_wdata", wb_wdata_o, wdata);
    chk("alu_noreq", 32'(dmem_req_o), 32'd0);
    chk("alu_nostall", 32'(stall_req_o), 32'd0);
  endtask

  // ack_cycle: Access cycle (1-based) in which ack is asserted; beyond Tmo means never.
  task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] rd,
                        input int ack_cycle);
    bit ld, timed_out;
    ld = m_is_load(op);
    timed_out = ack_cycle > int'(Tmo);
    ex_valid_i = 1'b1; ex_aluop_i = op; ex_mem_addr_i = addr; ex_store_data_i = sd;
    ex_wd_i = wd; ex_wreg_i = wreg; ex_wdata_i = $urandom;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if (m_misaligned(op, addr)) begin
      chk("al_valid", 32'(wb_valid_o), 32'd1);
      chk("al_wreg", 32'(wb_wreg_o), 32'd0);
      chk("al_wdata", wb_wdata_o, addr);
      chk("al_exc", 32'(align_exc_o), ld ? 32'd1 : 32'd2);
      chk("al_noreq", 32'(dmem_req_o), 32'd0);
      chk("al_nostall", 32'(stall_req_o), 32'd0);
      @(posedge clk); #1;
      chk("al_exc_clr", 32'(align_exc_o), 32'd0);
      return;
    end
`endif
    chk("cap_stall", 32'(stall_req_o), 32'd1);
    chk("cap_req", 32'(dmem_req_o), 32'd1);
    chk("cap_we", 32'(dmem_we_o), ld ? 32'd0 : 32'd1);
    chk("cap_addr", dmem_addr_o, addr - (addr % 4));
    chk("cap_be", 32'(dmem_be_o), 32'(m_be(op, addr)));
    if (!ld) chk("cap_wdata", dmem_wdata_o, m_wdata(op, sd));
    chk("cap_wbv", 32'(wb_valid_o), 32'd0);
    for (int k = 1; k <= int'(Tmo); k++) begin
      dmem_ack_i = (k == ack_cycle);
      dmem_rdata_i = rd;
      @(posedge clk); #1;
      dmem_ack_i = 1'b0;
      dmem_rdata_i = $urandom;
      if (k == ack_cycle || k == int'(Tmo)) break;
      chk("wait_stall", 32'(stall_req_o), 32'd1);
      chk("wait_req", 32'(dmem_req_o), 32'd1);
      chk("wait_be", 32'(dmem_be_o), 32'(m_be(op, addr)));
    end
    chk("done_stall", 32'(stall_req_o), 32'd0);
    chk("done_req", 32'(dmem_req_o), 32'd0);
    chk("done_valid", 32'(wb_valid_o), 32'd1);
    chk("done_wd", 32'(wb_wd_o), 32'(wd));
    chk("done_wreg", 32'(wb_wreg_o), (ld && !timed_out) ? 32'(wreg) : 32'd0);
    chk("done_berr", 32'(bus_err_o), timed_out ? 32'd1 : 32'd0);
    if (ld && !timed_out) chk("done_wdata", wb_wdata_o, m_load(op, addr, rd));
    @(posedge clk); #1;
    chk("bubble_valid", 32'(wb_valid_o), 32'd0);
    chk("bubble_berr", 32'(bus_err_o), 32'd0);
  endtask

  logic [7:0] mem_ops [8];
  logic [7:0] alu_ops [4];

  initial begin
    mem_ops = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};
    alu_ops = '{8'h21, 8'h23, 8'h24, 8'h25};
    reset_n = 1'b0; ex_valid_i = 1'b0; ex_aluop_i = '0; ex_mem_addr_i = '0;
    ex_store_data_i = '0; ex_wd_i = '0; ex_wreg_i = 1'b0; ex_wdata_i = '0;
    dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_be", 32'(dmem_be_o), 32'd0);
    chk("rst_wbv", 32'(wb_valid_o), 32'd0);
    chk("rst_wdata", wb_wdata_o, 32'd0);
    chk("rst_berr", 32'(bus_err_o), 32'd0);
    chk("rst_align", 32'(align_exc_o), 32'd0);
    reset_n = 1'b1;

    do_alu(8'h21, 5'd5, 1'b1, 32'h1234);
    do_mem(8'hE0, 32'h103, 32'h0, 5'd7, 1'b1, 32'h80FF_0000, 3);
    do_mem(8'hE9, 32'h102, 32'h0000_BEEF, 5'd8, 1'b1, 32'h0, 1);
    do_mem(8'hE5, 32'h200, 32'h0, 5'd9, 1'b1, 32'h0000_9ABC, 1);
    do_mem(8'hEB, 32'h300, 32'hCAFE_F00D, 5'd10, 1'b1, 32'h0, 99);
    do_mem(8'hE3, 32'h304, 32'h0, 5'd11, 1'b1, 32'h1357_9BDF, int'(Tmo));
    do_mem(8'hE3, 32'h101, 32'h0, 5'd12, 1'b1, 32'hA5A5_5A5A, 1);

    // Reset while an access is outstanding.
    ex_valid_i = 1'b1; ex_aluop_i = 8'hE3; ex_mem_addr_i = 32'h400; ex_wd_i = 5'd3;
    ex_wreg_i = 1'b1;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    chk("pre_rst_req", 32'(dmem_req_o), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_req", 32'(dmem_req_o), 32'd0);
    chk("mid_rst_stall", 32'(stall_req_o), 32'd0);
    chk("mid_rst_wbv", 32'(wb_valid_o), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_wbv", 32'(wb_valid_o), 32'd0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        do_alu(alu_ops[$urandom_range(0, 3)], 5'($urandom), 1'($urandom), $urandom);
      end else begin
        do_mem(mem_ops[$urandom_range(0, 7)], $urandom, $urandom, 5'($urandom), 1'($urandom),
               $urandom, int'($urandom_range(1, Tmo + 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
